// File: rtl/apb_requester.sv
// apb_requester: APB4 requester fed by a valid/ready command port.
//
// Commands are queued in a CMD_DEPTH-entry FIFO and issued one at a time as
// APB SETUP/ACCESS transfers. Each command returns exactly one response
// through a single registered response slot. Misaligned commands complete
// with an error and no bus transfer. An ACCESS phase that waits
// TIMEOUT_CYCLES cycles without pready is aborted with a timeout error.
// TIMEOUT_CYCLES = 0 disables the timeout.
//
// Ports
//   pclk, preset        clock (rising edge), async active-high reset
//   cmd_valid/ready     command handshake; cmd_ready = FIFO not full
//   cmd_write/addr/wdata/strb/prot   command fields
//   rsp_valid/ready     response handshake; rsp_valid is held until rsp_ready
//   rsp_rdata/err/timeout            response fields
//   psel, penable, pwrite, paddr, pwdata, pstrb, pprot   APB requester outputs
//   pready, pslverr, prdata                               APB completer inputs
module apb_requester #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic                    pready,
  input  logic                    pslverr,
  input  logic [DATA_WIDTH-1:0]   prdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W      = $clog2(CMD_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int TMR_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int ENTRY_W    = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH + 3;
  // Low address bits that must be zero for a full-width access.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  function automatic logic is_misaligned(input logic [ADDR_WIDTH-1:0] addr);
    return |(addr & ALIGN_MASK);
  endfunction

  state_t                  state, next_state;
  logic                    running;
  logic [ENTRY_W-1:0]      fifo_mem [CMD_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    full, empty, push, pop;
  logic [TMR_W-1:0]        timer;
  logic                    timer_clr, timer_inc, timer_hit;
  logic                    apb_load;
  logic                    rsp_load;
  logic [DATA_WIDTH-1:0]   rsp_rdata_nxt;
  logic                    rsp_err_nxt, rsp_tmo_nxt;

  logic                    head_write;
  logic [ADDR_WIDTH-1:0]   head_addr;
  logic [DATA_WIDTH-1:0]   head_wdata;
  logic [STRB_WIDTH-1:0]   head_strb;
  logic [2:0]              head_prot;

  // Command FIFO
  // cmd_ready is held low during reset and for the first edge after release,
  // so every output is 0 while preset is asserted.
  assign full      = (count == CNT_W'(CMD_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = running && !full;
  assign push      = cmd_valid && cmd_ready;
  assign {head_write, head_addr, head_wdata, head_strb, head_prot} = fifo_mem[rd_ptr];

  always_ff @(posedge pclk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot};
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      running <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      running <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Transfer FSM
  // psel/penable decode straight from the state register, so an async reset
  // drops them in the same cycle.
  assign psel      = (state != IDLE);
  assign penable   = (state == ACCESS);
  assign timer_hit = ((timer + TMR_W'(1)) == TMR_W'(TIMEOUT_CYCLES));

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state    = state;
    pop           = 1'b0;
    apb_load      = 1'b0;
    timer_clr     = 1'b0;
    timer_inc     = 1'b0;
    rsp_load      = 1'b0;
    rsp_rdata_nxt = '0;
    rsp_err_nxt   = 1'b0;
    rsp_tmo_nxt   = 1'b0;
    case (state)
      IDLE: begin
        // A pending response blocks the next command so it is never overwritten.
        if (!empty && !rsp_valid) begin
          if (is_misaligned(head_addr)) begin
            rsp_load    = 1'b1;
            rsp_err_nxt = 1'b1;
            pop         = 1'b1;
          end else begin
            apb_load   = 1'b1;
            timer_clr  = 1'b1;
            next_state = SETUP;
          end
        end
      end
      SETUP: next_state = ACCESS;
      ACCESS: begin
        if (pready) begin
          rsp_load      = 1'b1;
          rsp_err_nxt   = pslverr;
          rsp_rdata_nxt = (pwrite || pslverr) ? '0 : prdata;
          pop           = 1'b1;
          next_state    = IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && timer_hit) begin
          // This is the TIMEOUT_CYCLES-th wait cycle: abort the transfer.
          rsp_load    = 1'b1;
          rsp_err_nxt = 1'b1;
          rsp_tmo_nxt = 1'b1;
          pop         = 1'b1;
          next_state  = IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset)         timer <= '0;
    else if (timer_clr) timer <= '0;
    else if (timer_inc) timer <= timer + TMR_W'(1);
  end

  // APB address/data registers, loaded on entry to SETUP and held through ACCESS
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
      pstrb  <= '0;
      pprot  <= '0;
    end else if (apb_load) begin
      pwrite <= head_write;
      paddr  <= head_addr;
      pwdata <= head_write ? head_wdata : '0;
      pstrb  <= head_write ? head_strb : '0;
      pprot  <= head_prot;
    end
  end

  // Response slot
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (rsp_load) begin
      rsp_valid   <= 1'b1;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_tmo_nxt;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
module tb_apb_requester;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic [2:0]  cmd_prot = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic [31:0] prdata = '0;

  apb_requester #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .CMD_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic [31:0] rdata, input logic err, input logic tmo);
    rsp_t r;
    r.rdata = rdata;
    r.err   = err;
    r.tmo   = tmo;
    sb.push_back(r);
  endtask

  // Completer model: answers after cfg_wait ACCESS wait cycles, records the
  // SETUP-phase fields and flags any change during ACCESS.
  int          cfg_wait = 0;
  logic        cfg_err = 1'b0;
  int          acc_cnt = 0;
  int          last_access_len = 0;
  int          setups = 0;
  int          stable_err = 0;
  int          enable_no_setup = 0;
  logic        prev_setup = 1'b0;
  logic        cap_write = 1'b0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic [3:0]  cap_strb = '0;
  logic [2:0]  cap_prot = '0;

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (a == 32'h4) return 32'hDEADBEEF;
    return {16'hA0A0, a[15:0]};
  endfunction

  initial begin
    forever begin
      @(negedge pclk);
      if (psel && penable) begin
        if (acc_cnt == 0 && !prev_setup) enable_no_setup++;
        if ({pwrite, paddr, pwdata, pstrb, pprot} !== {cap_write, cap_addr, cap_wdata, cap_strb, cap_prot})
          stable_err++;
        pready  = (acc_cnt == cfg_wait);
        pslverr = pready && cfg_err;
        prdata  = pready ? rd_val(paddr) : 32'h0;
        acc_cnt++;
      end else begin
        if (acc_cnt != 0) last_access_len = acc_cnt;
        acc_cnt = 0;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0;
      end
      if (psel && !penable) begin
        setups++;
        cap_write = pwrite;
        cap_addr  = paddr;
        cap_wdata = pwdata;
        cap_strb  = pstrb;
        cap_prot  = pprot;
      end
      prev_setup = psel && !penable;
    end
  end

  // Response monitor: compares every consumed response with the scoreboard.
  initial begin
    rsp_t e;
    forever begin
      @(negedge pclk);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rdata=%h err=%b timeout=%b, expected no response",
                   rsp_rdata, rsp_err, rsp_timeout);
        end else begin
          e = sb.pop_front();
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          check("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
        end
      end
    end
  end

  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot);
    int n = 0;
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    cmd_prot  = prot;
    while (!cmd_ready && n < 200) begin
      @(negedge pclk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: cmd_ready stayed 0 for addr %h, expected 1", addr);
      cmd_valid = 1'b0;
    end else begin
      @(posedge pclk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge pclk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge pclk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int n;

    // Reset state
    repeat (3) @(negedge pclk);
    check("reset_apb_ctrl", 64'({psel, penable, pwrite}), 64'(3'b000));
    check("reset_apb_data", 64'({paddr, pwdata}), 64'(0));
    check("reset_strb_prot", 64'({pstrb, pprot}), 64'(0));
    check("reset_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'(3'b000));
    check("reset_rdata", 64'(rsp_rdata), 64'(0));
    check("reset_cmd_ready", 64'(cmd_ready), 64'(0));
    preset = 1'b0;
    repeat (2) @(negedge pclk);
    check("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));
    rsp_ready = 1'b1;

    // 1: zero-wait read, timing of psel/penable/rsp_valid
    cfg_wait = 0;
    expect_rsp(32'hDEADBEEF, 1'b0, 1'b0);
    send(1'b0, 32'h4, 32'hFFFF_FFFF, 4'hF, 3'b000);
    @(negedge pclk);
    check("t1_psel_c1", 64'({psel, penable}), 64'(2'b00));
    @(negedge pclk);
    check("t1_setup_c2", 64'({psel, penable}), 64'(2'b10));
    @(negedge pclk);
    check("t1_access_c3", 64'({psel, penable}), 64'(2'b11));
    @(negedge pclk);
    check("t1_idle_rsp_c4", 64'({psel, rsp_valid}), 64'(2'b01));
    drain();
    check("t1_read_pwdata", 64'(cap_wdata), 64'(0));
    check("t1_read_pstrb", 64'(cap_strb), 64'(0));
    check("t1_access_len", 64'(last_access_len), 64'(1));

    // 2: write with two wait states, fields held through ACCESS
    cfg_wait = 2;
    expect_rsp(32'h0, 1'b0, 1'b0);
    send(1'b1, 32'h8, 32'h12345678, 4'b0011, 3'b101);
    drain();
    check("t2_paddr", 64'(cap_addr), 64'(32'h8));
    check("t2_pwrite", 64'(cap_write), 64'(1));
    check("t2_pwdata", 64'(cap_wdata), 64'(32'h12345678));
    check("t2_pstrb", 64'(cap_strb), 64'(4'b0011));
    check("t2_pprot", 64'(cap_prot), 64'(3'b101));
    check("t2_stable", 64'(stable_err), 64'(0));
    check("t2_access_len", 64'(last_access_len), 64'(3));

    // 2b: write answered with pslverr
    cfg_wait = 0;
    cfg_err  = 1'b1;
    expect_rsp(32'h0, 1'b1, 1'b0);
    send(1'b1, 32'h44, 32'hCAFE0000, 4'hF, 3'b010);
    drain();
    cfg_err = 1'b0;

    // 3: misaligned read, no bus transfer
    s0 = setups;
    expect_rsp(32'h0, 1'b1, 1'b0);
    send(1'b0, 32'h3, 32'h0, 4'h0, 3'b000);
    @(negedge pclk);
    check("t3_rsp_c1", 64'(rsp_valid), 64'(0));
    @(negedge pclk);
    check("t3_rsp_c2", 64'({rsp_valid, rsp_err, psel}), 64'(3'b110));
    drain();
    check("t3_no_setup", 64'(setups - s0), 64'(0));

    // 4: completer never ready, timeout after 16 ACCESS cycles
    cfg_wait = 1000;
    expect_rsp(32'h0, 1'b1, 1'b1);
    send(1'b0, 32'h10, 32'h0, 4'h0, 3'b000);
    drain();
    check("t4_access_len", 64'(last_access_len), 64'(16));
    check("t4_psel_dropped", 64'({psel, penable}), 64'(2'b00));

    // 5: five commands with rsp_ready low; queue fills, one transfer, stall
    cfg_wait = 0;
    @(posedge pclk);
    #1 rsp_ready = 1'b0;
    s0 = setups;
    expect_rsp(32'hA0A0_0020, 1'b0, 1'b0);
    expect_rsp(32'hA0A0_0024, 1'b0, 1'b0);
    expect_rsp(32'hA0A0_0028, 1'b0, 1'b0);
    expect_rsp(32'hA0A0_002C, 1'b0, 1'b0);
    expect_rsp(32'hA0A0_0030, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(1'b0, 32'h20 + 32'(4 * i), 32'h0, 4'h0, 3'b000);
    repeat (6) @(negedge pclk);
    check("t5_full", 64'(cmd_ready), 64'(0));
    check("t5_one_transfer", 64'(setups - s0), 64'(1));
    check("t5_rsp_held", 64'({rsp_valid, psel}), 64'(2'b10));
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h60;
    repeat (3) @(negedge pclk);
    check("t5_still_full", 64'(cmd_ready), 64'(0));
    cmd_valid = 1'b0;
    @(posedge pclk);
    #1 rsp_ready = 1'b1;
    drain();
    check("t5_all_transfers", 64'(setups - s0), 64'(5));

    // 6: reset during ACCESS discards in-flight and queued commands
    cfg_wait = 1000;
    send(1'b0, 32'h50, 32'h0, 4'h0, 3'b000);
    send(1'b0, 32'h54, 32'h0, 4'h0, 3'b000);
    n = 0;
    while (!(psel && penable) && n < 50) begin
      @(negedge pclk);
      n++;
    end
    check("t6_reached_access", 64'({psel, penable}), 64'(2'b11));
    preset = 1'b1;
    #1;
    check("t6_reset_apb", 64'({psel, penable}), 64'(2'b00));
    check("t6_reset_rsp", 64'(rsp_valid), 64'(0));
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    s0 = setups;
    repeat (2) @(negedge pclk);
    check("t6_cmd_ready", 64'(cmd_ready), 64'(1));
    repeat (6) @(negedge pclk);
    check("t6_queue_discarded", 64'(setups - s0), 64'(0));
    cfg_wait = 0;
    expect_rsp(32'hDEADBEEF, 1'b0, 1'b0);
    send(1'b0, 32'h4, 32'h0, 4'h0, 3'b000);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
